// File: rtl/axi_lite_pkg.sv
// Shared definitions for the AXI4-Lite request scheduler: state encoding,
// response codes and the data width.
package axi_lite_pkg;

  localparam int DATA_W = 32;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_WR_ADDR = 3'd1;
  localparam logic [2:0] ST_WR_RESP = 3'd2;
  localparam logic [2:0] ST_RD_ADDR = 3'd3;
  localparam logic [2:0] ST_RD_RESP = 3'd4;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    WR_ADDR = ST_WR_ADDR,
    WR_RESP = ST_WR_RESP,
    RD_ADDR = ST_RD_ADDR,
    RD_RESP = ST_RD_RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: grants the first active request after
// the previously granted index, wrapping modulo N.
module rr_arbiter #(
  parameter int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic          found;
  logic [IW-1:0] pos;

  // Scan last+1, last+2, ... and stop at the first requester found.
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    pos   = '0;
    for (int k = 1; k <= N; k++) begin
      pos = IW'((int'(last) + k) % N);
      if (!found && req[pos]) begin
        found    = 1'b1;
        gnt[pos] = 1'b1;
        idx      = pos;
      end
    end
  end

endmodule

// File: rtl/axi_lite_req_sched.sv
// Round-robin scheduler sharing one AXI4-Lite slave between NREQ simple
// requesters, one transaction outstanding at a time.
// Optional response watchdog enabled by defining AXI_SCHED_TIMEOUT_EN.
module axi_lite_req_sched
  import axi_lite_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int AW     = 32,
  parameter int TO_CYC = 255
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ-1:0]        req_we,
  input  logic [NREQ*AW-1:0]     req_addr,
  input  logic [NREQ*DATA_W-1:0] req_wdata,
  output logic [NREQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [1:0]             rsp_resp,
  output logic [AW-1:0]          M_AWADDR,
  output logic                   M_AWVALID,
  input  logic                   M_AWREADY,
  output logic [DATA_W-1:0]      M_WDATA,
  output logic                   M_WVALID,
  input  logic                   M_WREADY,
  input  logic [1:0]             M_BRESP,
  input  logic                   M_BVALID,
  output logic                   M_BREADY,
  output logic [AW-1:0]          M_ARADDR,
  output logic                   M_ARVALID,
  input  logic                   M_ARREADY,
  input  logic [DATA_W-1:0]      M_RDATA,
  input  logic [1:0]             M_RRESP,
  input  logic                   M_RVALID,
  output logic                   M_RREADY
);

  localparam int IW = $clog2(NREQ);

  state_t              state, state_n;
  logic [IW-1:0]       last_q, last_n, cur_q, cur_n;
  logic [NREQ-1:0]     gnt;
  logic [IW-1:0]       gnt_idx;
  logic                aw_valid_q, aw_valid_n, w_valid_q, w_valid_n;
  logic                ar_valid_q, ar_valid_n, b_ready_q, b_ready_n;
  logic                r_ready_q, r_ready_n;
  logic [AW-1:0]       awaddr_q, awaddr_n, araddr_q, araddr_n, addr_sel;
  logic [DATA_W-1:0]   wdata_q, wdata_n, wdata_sel;
  logic [NREQ-1:0]     rsp_valid_q, rsp_valid_n;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_n;
  logic [1:0]          rsp_resp_q, rsp_resp_n;

`ifdef AXI_SCHED_TIMEOUT_EN
  localparam int CW = ($clog2(TO_CYC + 1) > 8) ? $clog2(TO_CYC + 1) : 8;
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYC - 1);
  logic [CW-1:0] cnt_q, cnt_n;
`else
  localparam int unused_to_cyc = TO_CYC;
`endif

  rr_arbiter #(.N(NREQ)) u_arb (
    .req  (req_valid),
    .last (last_q),
    .gnt  (gnt),
    .idx  (gnt_idx)
  );

  // Pick out the granted requester's address and write data.
  always_comb begin
    addr_sel  = req_addr[0 +: AW];
    wdata_sel = req_wdata[0 +: DATA_W];
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_idx == IW'(i)) begin
        addr_sel  = req_addr[i*AW +: AW];
        wdata_sel = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  // Next-state and channel sequencing; everything holds unless a handshake moves it.
  always_comb begin
    state_n     = state;
    last_n      = last_q;
    cur_n       = cur_q;
    aw_valid_n  = aw_valid_q;
    w_valid_n   = w_valid_q;
    ar_valid_n  = ar_valid_q;
    b_ready_n   = b_ready_q;
    r_ready_n   = r_ready_q;
    awaddr_n    = awaddr_q;
    araddr_n    = araddr_q;
    wdata_n     = wdata_q;
    rsp_valid_n = '0;
    rsp_rdata_n = rsp_rdata_q;
    rsp_resp_n  = rsp_resp_q;
    req_ready   = '0;
`ifdef AXI_SCHED_TIMEOUT_EN
    cnt_n       = cnt_q;
`endif
    unique case (state)
      IDLE: begin
        if (|gnt) begin
          req_ready = gnt;
          last_n    = gnt_idx;
          cur_n     = gnt_idx;
          if (req_we[gnt_idx]) begin
            state_n    = WR_ADDR;
            aw_valid_n = 1'b1;
            w_valid_n  = 1'b1;
            awaddr_n   = addr_sel;
            wdata_n    = wdata_sel;
          end else begin
            state_n    = RD_ADDR;
            ar_valid_n = 1'b1;
            araddr_n   = addr_sel;
          end
        end
      end
      WR_ADDR: begin
        if (M_AWREADY) aw_valid_n = 1'b0;
        if (M_WREADY)  w_valid_n  = 1'b0;
        if ((!aw_valid_q || M_AWREADY) && (!w_valid_q || M_WREADY)) begin
          state_n   = WR_RESP;
          b_ready_n = 1'b1;
`ifdef AXI_SCHED_TIMEOUT_EN
          cnt_n     = '0;
`endif
        end
      end
      WR_RESP: begin
`ifdef AXI_SCHED_TIMEOUT_EN
        cnt_n = cnt_q + CW'(1);
`endif
        if (M_BVALID && b_ready_q) begin
          state_n            = IDLE;
          b_ready_n          = 1'b0;
          rsp_valid_n[cur_q] = 1'b1;
          rsp_resp_n         = M_BRESP;
          rsp_rdata_n        = '0;
        end
`ifdef AXI_SCHED_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_n            = IDLE;
          b_ready_n          = 1'b0;
          rsp_valid_n[cur_q] = 1'b1;
          rsp_resp_n         = RESP_SLVERR;
          rsp_rdata_n        = '0;
        end
`endif
      end
      RD_ADDR: begin
        if (M_ARREADY) begin
          state_n    = RD_RESP;
          ar_valid_n = 1'b0;
          r_ready_n  = 1'b1;
`ifdef AXI_SCHED_TIMEOUT_EN
          cnt_n      = '0;
`endif
        end
      end
      RD_RESP: begin
`ifdef AXI_SCHED_TIMEOUT_EN
        cnt_n = cnt_q + CW'(1);
`endif
        if (M_RVALID && r_ready_q) begin
          state_n            = IDLE;
          r_ready_n          = 1'b0;
          rsp_valid_n[cur_q] = 1'b1;
          rsp_resp_n         = M_RRESP;
          rsp_rdata_n        = M_RDATA;
        end
`ifdef AXI_SCHED_TIMEOUT_EN
        else if (cnt_q == TO_LAST) begin
          state_n            = IDLE;
          r_ready_n          = 1'b0;
          rsp_valid_n[cur_q] = 1'b1;
          rsp_resp_n         = RESP_SLVERR;
          rsp_rdata_n        = '0;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // State register; reset abandons any in-flight transaction silently.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state       <= IDLE;
      last_q      <= IW'(NREQ - 1);
      cur_q       <= '0;
      aw_valid_q  <= 1'b0;
      w_valid_q   <= 1'b0;
      ar_valid_q  <= 1'b0;
      b_ready_q   <= 1'b0;
      r_ready_q   <= 1'b0;
      awaddr_q    <= '0;
      araddr_q    <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_resp_q  <= RESP_OKAY;
`ifdef AXI_SCHED_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state       <= state_n;
      last_q      <= last_n;
      cur_q       <= cur_n;
      aw_valid_q  <= aw_valid_n;
      w_valid_q   <= w_valid_n;
      ar_valid_q  <= ar_valid_n;
      b_ready_q   <= b_ready_n;
      r_ready_q   <= r_ready_n;
      awaddr_q    <= awaddr_n;
      araddr_q    <= araddr_n;
      wdata_q     <= wdata_n;
      rsp_valid_q <= rsp_valid_n;
      rsp_rdata_q <= rsp_rdata_n;
      rsp_resp_q  <= rsp_resp_n;
`ifdef AXI_SCHED_TIMEOUT_EN
      cnt_q       <= cnt_n;
`endif
    end
  end

  assign M_AWADDR  = awaddr_q;
  assign M_AWVALID = aw_valid_q;
  assign M_WDATA   = wdata_q;
  assign M_WVALID  = w_valid_q;
  assign M_BREADY  = b_ready_q;
  assign M_ARADDR  = araddr_q;
  assign M_ARVALID = ar_valid_q;
  assign M_RREADY  = r_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_resp  = rsp_resp_q;

endmodule

// File: tb/tb_axi_lite_req_sched.sv
// Directed testbench for axi_lite_req_sched with a small AXI4-Lite slave model.
// The timeout step runs only when AXI_SCHED_TIMEOUT_EN is defined.
module tb_axi_lite_req_sched;

  localparam int NREQ = 2;
  localparam int AW   = 32;

  logic              ACLK = 1'b0;
  logic              ARESETn = 1'b0;
  logic [NREQ-1:0]   req_valid, req_ready, req_we, rsp_valid;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*32-1:0] req_wdata;
  logic [31:0]       rsp_rdata;
  logic [1:0]        rsp_resp;
  logic [AW-1:0]     M_AWADDR, M_ARADDR;
  logic [31:0]       M_WDATA, M_RDATA;
  logic              M_AWVALID, M_AWREADY, M_WVALID, M_WREADY, M_BVALID, M_BREADY;
  logic              M_ARVALID, M_ARREADY, M_RVALID, M_RREADY;
  logic [1:0]        M_BRESP, M_RRESP;

  int compared   = 0;
  int mismatched = 0;

  // Slave model knobs and state
  logic        aw_en = 1'b1, w_en = 1'b1, r_en = 1'b1;
  logic [1:0]  bresp_val = 2'b00;
  logic [31:0] mem [256];
  logic        mem_ready = 1'b0;
  logic        bvalid_q = 1'b0, rvalid_q = 1'b0, got_aw = 1'b0, got_w = 1'b0;
  logic [31:0] rdata_q = '0, aw_lat = '0, w_lat = '0;
  int          b_count = 0;
  logic [7:0]  grant_seq;
  int          ngrant, bcount0;

  wire aw_hs = M_AWVALID & M_AWREADY;
  wire w_hs  = M_WVALID & M_WREADY;
  wire ar_hs = M_ARVALID & M_ARREADY;

  assign M_AWREADY = aw_en;
  assign M_WREADY  = w_en;
  assign M_ARREADY = 1'b1;
  assign M_BVALID  = bvalid_q;
  assign M_BRESP   = bresp_val;
  assign M_RVALID  = rvalid_q;
  assign M_RDATA   = rdata_q;
  assign M_RRESP   = 2'b00;

  axi_lite_req_sched #(.NREQ(NREQ), .AW(AW), .TO_CYC(16)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_resp(rsp_resp),
    .M_AWADDR(M_AWADDR), .M_AWVALID(M_AWVALID), .M_AWREADY(M_AWREADY),
    .M_WDATA(M_WDATA), .M_WVALID(M_WVALID), .M_WREADY(M_WREADY),
    .M_BRESP(M_BRESP), .M_BVALID(M_BVALID), .M_BREADY(M_BREADY),
    .M_ARADDR(M_ARADDR), .M_ARVALID(M_ARVALID), .M_ARREADY(M_ARREADY),
    .M_RDATA(M_RDATA), .M_RRESP(M_RRESP), .M_RVALID(M_RVALID), .M_RREADY(M_RREADY)
  );

  always #5 ACLK = ~ACLK;

  // Word-addressed slave: commits a write once both AW and W have been seen,
  // returns B the following cycle and R one cycle after AR (unless r_en is low).
  always @(posedge ACLK) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'hA000_0000 | 32'(i);
      mem_ready <= 1'b1;
    end
    if (!ARESETn) begin
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      got_aw   <= 1'b0;
      got_w    <= 1'b0;
    end else begin
      if (bvalid_q && M_BREADY) begin
        bvalid_q <= 1'b0;
        b_count  <= b_count + 1;
      end
      if (aw_hs) begin got_aw <= 1'b1; aw_lat <= M_AWADDR; end
      if (w_hs)  begin got_w  <= 1'b1; w_lat  <= M_WDATA;  end
      if ((got_aw || aw_hs) && (got_w || w_hs)) begin
        mem[aw_hs ? M_AWADDR[9:2] : aw_lat[9:2]] <= w_hs ? M_WDATA : w_lat;
        bvalid_q <= 1'b1;
        got_aw   <= 1'b0;
        got_w    <= 1'b0;
      end
      if (rvalid_q && M_RREADY) rvalid_q <= 1'b0;
      if (ar_hs) begin
        rdata_q <= mem[M_ARADDR[9:2]];
        if (r_en) rvalid_q <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int idx, input logic we, input logic [31:0] addr, input logic [31:0] data);
    req_valid[idx]            = 1'b1;
    req_we[idx]               = we;
    req_addr[idx*AW +: AW]    = addr;
    req_wdata[idx*32 +: 32]   = data;
  endtask

  task automatic dropRequest(input int idx);
    req_valid[idx] = 1'b0;
  endtask

  task automatic waitRsp(input string tag, input logic [NREQ-1:0] expected);
    for (int n = 0; n < 40 && rsp_valid == '0; n++) tick();
    checkOutput(tag, 32'(rsp_valid), 32'(expected));
  endtask

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    ARESETn = 1'b0;
    repeat (3) tick();
    checkOutput("reset_valids", 32'({M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY}), 32'h0);
    checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'h0);
    checkOutput("reset_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("reset_rsp_resp", 32'(rsp_resp), 32'h0);
    checkOutput("reset_awaddr", M_AWADDR, 32'h0);
    ARESETn = 1'b1;
    tick();

    // Single write from requester 0, minimum latency
    applyStimulus(0, 1'b1, 32'h10, 32'hDEADBEEF);
    #1;
    checkOutput("wr_grant", 32'(req_ready), 32'h1);
    tick();
    dropRequest(0);
    checkOutput("wr_valids", 32'({M_AWVALID, M_WVALID}), 32'h3);
    checkOutput("wr_awaddr", M_AWADDR, 32'h10);
    checkOutput("wr_wdata", M_WDATA, 32'hDEADBEEF);
    checkOutput("wr_ready_busy", 32'(req_ready), 32'h0);
    tick();
    checkOutput("wr_bready", 32'({M_AWVALID, M_WVALID, M_BREADY}), 32'h1);
    tick();
    checkOutput("wr_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("wr_rsp_resp", 32'(rsp_resp), 32'h0);
    checkOutput("wr_rsp_rdata", rsp_rdata, 32'h0);
    tick();
    checkOutput("wr_rsp_pulse", 32'(rsp_valid), 32'h0);

    // Read back the same word
    applyStimulus(0, 1'b0, 32'h10, 32'h0);
    #1;
    checkOutput("rd_grant", 32'(req_ready), 32'h1);
    tick();
    dropRequest(0);
    checkOutput("rd_arvalid", 32'({M_ARVALID, M_RREADY}), 32'h2);
    checkOutput("rd_araddr", M_ARADDR, 32'h10);
    tick();
    checkOutput("rd_rready", 32'({M_ARVALID, M_RREADY}), 32'h1);
    tick();
    checkOutput("rd_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("rd_rsp_rdata", rsp_rdata, 32'hDEADBEEF);
    checkOutput("rd_rsp_resp", 32'(rsp_resp), 32'h0);
    tick();

    // Contention from a fresh reset: grants alternate 0,1,0,1
    ARESETn = 1'b0;
    tick();
    ARESETn = 1'b1;
    applyStimulus(0, 1'b1, 32'h0, 32'h11);
    applyStimulus(1, 1'b1, 32'h4, 32'h22);
    ngrant = 0;
    grant_seq = '0;
    for (int n = 0; n < 40 && ngrant < 4; n++) begin
      #1;
      if (req_ready != '0) begin
        grant_seq[ngrant*2 +: 2] = req_ready;
        ngrant++;
      end
      tick();
    end
    dropRequest(0);
    dropRequest(1);
    checkOutput("cont_ngrant", 32'(ngrant), 32'd4);
    checkOutput("cont_order", 32'(grant_seq), 32'h99);
    waitRsp("cont_last_rsp", 2'b10);
    tick();
    checkOutput("cont_mem0", mem[0], 32'h11);
    checkOutput("cont_mem1", mem[1], 32'h22);

    // AW backpressure: W completes first, AW held 3 cycles with stable address
    aw_en = 1'b0;
    bresp_val = 2'b10;
    bcount0 = b_count;
    applyStimulus(0, 1'b1, 32'h20, 32'h55AA0F0F);
    #1;
    checkOutput("bp_grant", 32'(req_ready), 32'h1);
    tick();
    dropRequest(0);
    checkOutput("bp_valids", 32'({M_AWVALID, M_WVALID}), 32'h3);
    tick();
    checkOutput("bp_w_drop", 32'({M_AWVALID, M_WVALID}), 32'h2);
    tick();
    checkOutput("bp_aw_hold1", 32'({M_AWVALID, M_WVALID}), 32'h2);
    checkOutput("bp_awaddr1", M_AWADDR, 32'h20);
    tick();
    checkOutput("bp_aw_hold2", 32'({M_AWVALID, M_WVALID}), 32'h2);
    checkOutput("bp_awaddr2", M_AWADDR, 32'h20);
    aw_en = 1'b1;
    tick();
    checkOutput("bp_bready", 32'({M_AWVALID, M_WVALID, M_BREADY}), 32'h1);
    tick();
    checkOutput("bp_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("bp_rsp_resp", 32'(rsp_resp), 32'h2);
    checkOutput("bp_rsp_rdata", rsp_rdata, 32'h0);
    tick();
    tick();
    checkOutput("bp_one_b", 32'(b_count - bcount0), 32'd1);
    checkOutput("bp_mem8", mem[8], 32'h55AA0F0F);
    bresp_val = 2'b00;

    // Reset while waiting in RD_RESP
    r_en = 1'b0;
    applyStimulus(1, 1'b0, 32'h10, 32'h0);
    #1;
    checkOutput("mr_grant", 32'(req_ready), 32'h2);
    tick();
    dropRequest(1);
    tick();
    checkOutput("mr_rready", 32'(M_RREADY), 32'h1);
    ARESETn = 1'b0;
    tick();
    checkOutput("mr_valids", 32'({M_AWVALID, M_WVALID, M_ARVALID, M_BREADY, M_RREADY}), 32'h0);
    checkOutput("mr_no_rsp", 32'(rsp_valid), 32'h0);
    ARESETn = 1'b1;
    r_en = 1'b1;
    applyStimulus(0, 1'b0, 32'h10, 32'h0);
    applyStimulus(1, 1'b0, 32'h4, 32'h0);
    #1;
    checkOutput("mr_rr_restart", 32'(req_ready), 32'h1);
    tick();
    dropRequest(0);
    dropRequest(1);
    waitRsp("mr_rsp", 2'b01);
    checkOutput("mr_rdata", rsp_rdata, 32'hDEADBEEF);
    tick();

    // Back-to-back reads by requester 1: next grant in the rsp_valid cycle
    applyStimulus(1, 1'b0, 32'h8, 32'h0);
    #1;
    checkOutput("b2b_grant1", 32'(req_ready), 32'h2);
    tick();
    applyStimulus(1, 1'b0, 32'hC, 32'h0);
    tick();
    tick();
    checkOutput("b2b_rsp1", 32'(rsp_valid), 32'h2);
    checkOutput("b2b_ready_same", 32'(req_ready), 32'h2);
    checkOutput("b2b_rdata1", rsp_rdata, 32'hA0000002);
    tick();
    dropRequest(1);
    checkOutput("b2b_pulse", 32'(rsp_valid), 32'h0);
    checkOutput("b2b_araddr2", M_ARADDR, 32'hC);
    waitRsp("b2b_rsp2", 2'b10);
    checkOutput("b2b_rdata2", rsp_rdata, 32'hA0000003);
    tick();

`ifdef AXI_SCHED_TIMEOUT_EN
    // Slave never answers the read: SLVERR after 16 cycles in RD_RESP
    r_en = 1'b0;
    applyStimulus(0, 1'b0, 32'h0, 32'h0);
    tick();
    dropRequest(0);
    tick();
    repeat (15) tick();
    checkOutput("to_before", 32'(rsp_valid), 32'h0);
    tick();
    checkOutput("to_rsp_valid", 32'(rsp_valid), 32'h1);
    checkOutput("to_rsp_resp", 32'(rsp_resp), 32'h2);
    checkOutput("to_rsp_rdata", rsp_rdata, 32'h0);
    checkOutput("to_rready", 32'(M_RREADY), 32'h0);
    r_en = 1'b1;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time limit so the bench always ends on its own
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed no completion expected finish before time limit");
    $fatal(1, "[TB] time limit reached");
  end

endmodule

// File: doc/axi_lite_req_sched.md
Name: axi_lite_req_sched

Overview:
- Shares one AXI4-Lite slave (256x32 word memory at addr[9:2]) between NREQ simple requesters.
- Round-robin arbitration; one transaction outstanding at a time.
- Sequences the AW/W/B or AR/R channels for the winner and returns a one-cycle response pulse.
- Sits between the CPU-side and DMA-side request ports and the AXI slave.

Parameters:
- NREQ, 2, number of requesters (2..8)
- AW, 32, address width
- TO_CYC, 255, response watchdog limit in cycles (used only with AXI_SCHED_TIMEOUT_EN)

Ports:
- ACLK  in  1  clock, rising edge
- ARESETn  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester request
- req_ready  out  NREQ  one-hot accept, combinational in IDLE
- req_we  in  NREQ  1=write, 0=read
- req_addr  in  NREQ*AW  packed addresses, requester i at [i*AW +: AW]
- req_wdata  in  NREQ*32  packed write data
- rsp_valid  out  NREQ  one-hot completion pulse
- rsp_rdata  out  32  read data (0 for writes)
- rsp_resp  out  2  BRESP/RRESP of completed transaction
- M_AWADDR  out  AW  write address
- M_AWVALID  out  1  write address valid
- M_AWREADY  in  1  write address ready
- M_WDATA  out  32  write data
- M_WVALID  out  1  write data valid
- M_WREADY  in  1  write data ready
- M_BRESP  in  2  write response
- M_BVALID  in  1  write response valid
- M_BREADY  out  1  write response ready
- M_ARADDR  out  AW  read address
- M_ARVALID  out  1  read address valid
- M_ARREADY  in  1  read address ready
- M_RDATA  in  32  read data
- M_RRESP  in  2  read response
- M_RVALID  in  1  read data valid
- M_RREADY  out  1  read data ready

Behaviour:
- Reset (ARESETn=0 at a rising edge, including mid-transaction):
  - state=IDLE; all M_*VALID, M_BREADY, M_RREADY, rsp_valid = 0.
  - rsp_rdata=0, rsp_resp=0, M_AWADDR/M_ARADDR/M_WDATA=0.
  - RR pointer last=NREQ-1, so requester 0 has priority first.
  - An in-flight transaction is abandoned; no rsp_valid is issued.
- State machine: IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_RESP.
- IDLE:
  - Grant g = first i with req_valid[i], scanning last+1, last+2, ... modulo NREQ.
  - req_ready[g]=1 combinationally; req_ready is 0 in every other state.
  - At the edge: latch addr/wdata of g, set last=g.
  - Go to WR_ADDR with M_AWVALID=M_WVALID=1 if req_we[g], else RD_ADDR with M_ARVALID=1.
- WR_ADDR:
  - AW and W are raised in the same cycle, and each valid drops on its own handshake (VALID&READY).
  - Address and data stay stable while their valid is high.
  - Once both handshakes are done (same or different cycles), go to WR_RESP with M_BREADY=1.
- WR_RESP:
  - On M_BVALID&M_BREADY: M_BREADY=0; rsp_valid[g]=1 next cycle; rsp_resp=M_BRESP; rsp_rdata=0; go to IDLE.
- RD_ADDR:
  - On M_ARVALID&M_ARREADY: M_ARVALID=0; go to RD_RESP with M_RREADY=1.
- RD_RESP:
  - On M_RVALID&M_RREADY: rsp_rdata=M_RDATA, rsp_resp=M_RRESP, rsp_valid[g]=1 for one cycle; go to IDLE.
- Handshake rules:
  - A B or R beat arriving in the same cycle as entry to the *_RESP state is not accepted; it is held by the slave per AXI.
  - rsp_valid is exactly one cycle. rsp_rdata/rsp_resp hold until the next completion.
  - The IDLE state in which rsp_valid is high may already grant the next request; back-to-back throughput is therefore 1 grant per (transaction + 1) cycles.
- Requester rules:
  - A requester dropping req_valid before req_ready is legal; its request is simply not taken.
  - Simultaneous requests are resolved only by RR. A continuously requesting requester waits at most NREQ-1 grants.
- Minimum latency (slave ready immediately): req accept at T0, valids at T1, response ready asserted T2, rsp_valid T3 or later.

Optional Feature:
- Macro: AXI_SCHED_TIMEOUT_EN.
- Defined:
  - An 8-bit+ counter clears on entry to WR_RESP/RD_RESP and increments each cycle there.
  - When the count reaches TO_CYC: complete with rsp_resp=2'b10 (SLVERR), rsp_rdata=0, drop M_BREADY/M_RREADY, go to IDLE.
  - A late B/R beat is then ignored.
- Not defined: no counter; the block waits indefinitely in *_RESP.

Decomposition:
- Shared package axi_lite_pkg:
  - state encoding (3-bit localparams for the five states)
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10
  - DATA_W=32
- Sub-module rr_arbiter: params N; inputs req[N], last[$clog2(N)]; output one-hot gnt[N] and index. Purely combinational; reusable by other schedulers.

Test Plan:
- Single write then read: req0 writes addr 0x10 data 0xDEADBEEF, then reads 0x10 -> rsp_valid[0] pulses twice, rsp_resp=00, second rsp_rdata=0xDEADBEEF.
- Contention: req0 and req1 both valid continuously, req0 writes 0x0/0x11, req1 writes 0x4/0x22 -> grants alternate 0,1,0,1; memory words 0 and 1 hold 0x11 and 0x22.
- Slave backpressure: M_AWREADY delayed 3 cycles after M_WREADY -> M_WVALID drops first, M_AWVALID held with stable addr, exactly one B accepted.
- Mid-transaction reset: ARESETn low for 1 cycle while in RD_RESP -> next cycle all valids/readys 0, no rsp_valid; the next request is served from requester 0.
- With AXI_SCHED_TIMEOUT_EN, TO_CYC=16, slave never asserts M_RVALID -> rsp_valid after 16 cycles in RD_RESP with rsp_resp=2'b10, rsp_rdata=0.
- Back-to-back reads by req1 to 0x8, 0xC -> second req_ready asserted in the same cycle as the first rsp_valid[1].
